// File: rtl/rom_tx_sequencer.sv
// rom_tx_sequencer: walks a synchronous message ROM from address 0 and hands each byte to the
// UART transmitter over the tx_start/tx_busy handshake. A message stops at the terminator byte
// (which is never sent) or after the last ROM address. It never wraps.
//
// Ports
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : 1-cycle request to send the message; ignored while busy
//   abort       : synchronous abort back to idle; no done pulse
//   rom_addr    : ROM read address; rom_data is valid one clock after it
//   tx_data     : byte presented to the transmitter, held until the next byte is loaded
//   tx_start    : 1-cycle transmit request
//   tx_busy     : transmitter busy; rises after tx_start, falls at the end of the stop bit
//   busy        : high whenever a message is in progress
//   done        : 1-cycle pulse when a message completes normally
//   byte_count  : bytes sent in the current or most recent message
module rom_tx_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR = '0,
  parameter int unsigned           GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   byte_count
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    StIdle,
    StRead,
    StCheck,
    StSend,
    StAck,
    StDrain,
    StGap,
    StNext,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    tx_data_d    = tx_data_q;
    byte_count_d = byte_count_q;
    gap_cnt_d    = gap_cnt_q;
    tx_start     = 1'b0;

    unique case (state_q)
      StIdle: begin
        rom_addr_d = '0;
        if (start) begin
          byte_count_d = '0;
          state_d      = StRead;
        end
      end
      // One clock for the synchronous ROM to present the addressed byte.
      StRead: state_d = StCheck;
      StCheck: begin
        if (rom_data == TERMINATOR) begin
          state_d = StDone;
        end else begin
          tx_data_d = rom_data;
          state_d   = StSend;
        end
      end
      // tx_start is combinational so the request goes out in the first SEND clock.
      StSend: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = StAck;
        end
      end
      StAck: begin
        if (tx_busy) state_d = StDrain;
      end
      StDrain: begin
        if (!tx_busy) begin
          byte_count_d = byte_count_q + (ADDR_WIDTH + 1)'(1);
          gap_cnt_d    = '0;
          state_d      = (GAP_CYCLES > 0) ? StGap : StNext;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          state_d   = StNext;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      StNext: begin
        if (rom_addr_q == '1) begin
          state_d = StDone;
        end else begin
          rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
          state_d    = StRead;
        end
      end
      StDone: begin
        rom_addr_d = '0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides every transition, including a start in idle. A byte the transmitter
    // already accepted finishes on the line but is not counted.
    if (abort) begin
      state_d      = StIdle;
      rom_addr_d   = '0;
      tx_data_d    = tx_data_q;
      byte_count_d = byte_count_q;
      gap_cnt_d    = '0;
      tx_start     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rom_addr_q   <= '0;
      tx_data_q    <= '0;
      byte_count_q <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      tx_data_q    <= tx_data_d;
      byte_count_q <= byte_count_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign tx_data    = tx_data_q;
  assign byte_count = byte_count_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_rom_tx_sequencer.sv
// Bench for rom_tx_sequencer. Two instances share one 8-entry ROM image: index 0 has no
// inter-byte gap, index 1 has a 5-clock gap. Each has its own registered ROM port and a
// transmitter model that is busy for Frame clocks starting the clock after tx_start.
`timescale 1ns/1ps
module tb_rom_tx_sequencer;
  localparam int AW    = 3;
  localparam int Depth = 8;
  localparam int Frame = 10;
  localparam int Gap1  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    rom_mem [Depth];
  logic          start_a [2];
  logic          abort_a [2];
  logic          hold_a  [2];
  logic [AW-1:0] rom_addr_a [2];
  logic [7:0]    rom_data_a [2];
  logic [7:0]    tx_data_a [2];
  logic          tx_start_a [2];
  logic          tx_busy_a [2];
  logic          busy_a [2];
  logic          done_a [2];
  logic [AW:0]   byte_count_a [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, written only by the monitors below.
  int         ts_cnt [2]   = '{0, 0};
  int         ts_cyc [2]   = '{0, 0};
  int         done_cnt [2] = '{0, 0};
  int         done_cyc [2] = '{0, 0};
  int         fall_cyc [2] = '{0, 0};
  logic [7:0] sent_mem [2][16];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int   busy_left = 0;
    logic busy_prev = 1'b0;

    rom_tx_sequencer #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(8),
      .TERMINATOR(8'h00),
      .GAP_CYCLES((g == 0) ? 0 : Gap1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_a[g]),
      .abort     (abort_a[g]),
      .rom_addr  (rom_addr_a[g]),
      .rom_data  (rom_data_a[g]),
      .tx_data   (tx_data_a[g]),
      .tx_start  (tx_start_a[g]),
      .tx_busy   (tx_busy_a[g]),
      .busy      (busy_a[g]),
      .done      (done_a[g]),
      .byte_count(byte_count_a[g])
    );

    always @(posedge clk) begin
      rom_data_a[g] <= rom_mem[rom_addr_a[g]];
      if (tx_start_a[g]) busy_left <= Frame;
      else if (busy_left > 0) busy_left <= busy_left - 1;
    end
    assign tx_busy_a[g] = (busy_left > 0) || hold_a[g];

    always @(negedge clk) begin
      busy_prev <= tx_busy_a[g];
      if (tx_start_a[g]) begin
        sent_mem[g][ts_cnt[g] % 16] <= tx_data_a[g];
        ts_cnt[g] <= ts_cnt[g] + 1;
        ts_cyc[g] <= cyc;
      end
      if (done_a[g]) begin
        done_cnt[g] <= done_cnt[g] + 1;
        done_cyc[g] <= cyc;
      end
      if (busy_prev && !tx_busy_a[g]) fall_cyc[g] <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d, output int k);
    start_a[d] = 1'b1;
    k = cyc;
    tick();
    start_a[d] = 1'b0;
  endtask

  task automatic wait_ts(input int d, input int target, input string tag);
    for (int t = 0; t < 300 && ts_cnt[d] < target; t++) tick();
    check({tag, " tx_start reached"}, 32'(ts_cnt[d] >= target), 1);
  endtask

  task automatic wait_done(input int d, input int dbase, input string tag);
    for (int t = 0; t < 400 && done_cnt[d] == dbase; t++) tick();
    tick();
    check({tag, " done one clk"}, 32'(done_cnt[d] - dbase), 1);
    check({tag, " busy after done"}, 32'(busy_a[d]), 0);
  endtask

  // Reference: message length is the index of the first terminator, or the full ROM.
  function automatic int msg_len();
    for (int j = 0; j < Depth; j++) if (rom_mem[j] == 8'h00) return j;
    return Depth;
  endfunction

  task automatic load_str(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4);
    for (int j = 0; j < Depth; j++) rom_mem[j] = 8'($urandom_range(1, 255));
    rom_mem[0] = b0; rom_mem[1] = b1; rom_mem[2] = b2; rom_mem[3] = b3; rom_mem[4] = b4;
  endtask

  task automatic check_msg(input int d, input int base, input string tag);
    int len;
    len = msg_len();
    check({tag, " tx_start count"}, 32'(ts_cnt[d] - base), 32'(len));
    check({tag, " byte_count"}, 32'(byte_count_a[d]), 32'(len));
    for (int j = 0; j < len; j++)
      check({tag, " byte"}, 32'(sent_mem[d][(base + j) % 16]), 32'(rom_mem[j]));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, base, dbase, s1, s2, r;
    start_a = '{1'b0, 1'b0};
    abort_a = '{1'b0, 1'b0};
    hold_a  = '{1'b0, 1'b0};
    load_str(8'h48, 8'h69, 8'h00, 8'h00, 8'h00);

    // Reset values.
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("reset rom_addr", 32'(rom_addr_a[d]), 0);
      check("reset tx_data", 32'(tx_data_a[d]), 0);
      check("reset tx_start", 32'(tx_start_a[d]), 0);
      check("reset done", 32'(done_a[d]), 0);
      check("reset busy", 32'(busy_a[d]), 0);
      check("reset byte_count", 32'(byte_count_a[d]), 0);
    end
    rst_n = 1'b1;
    tick();

    // "Hi": first tx_start lands in SEND, three clocks after the start clock; each byte then
    // takes the model frame (busy from s+1 to s+Frame) plus DRAIN-low, NEXT, READ, CHECK.
    base = ts_cnt[0]; dbase = done_cnt[0];
    pulse_start(0, k);
    wait_ts(0, base + 1, "hi first");
    check("hi start latency", 32'(ts_cyc[0] - k), 3);
    s1 = ts_cyc[0];
    repeat (4) tick();
    check("hi tx_data held", 32'(tx_data_a[0]), 32'h48);
    wait_ts(0, base + 2, "hi second");
    s2 = ts_cyc[0];
    check("hi byte period", 32'(s2 - s1), 32'(Frame + 5));
    wait_done(0, dbase, "hi");
    check("hi done timing", 32'(done_cyc[0] - s2), 32'(Frame + 5));
    check_msg(0, base, "hi");
    repeat (3) tick();
    check("hi byte_count holds", 32'(byte_count_a[0]), 2);

    // Terminator at address 0: READ, CHECK, DONE with nothing sent.
    load_str(8'h00, 8'h41, 8'h42, 8'h00, 8'h00);
    base = ts_cnt[0]; dbase = done_cnt[0];
    pulse_start(0, k);
    wait_done(0, dbase, "empty");
    check("empty done latency", 32'(done_cyc[0] - k), 3);
    check_msg(0, base, "empty");

    // Full ROM, no terminator: all 8 bytes, then back to address 0.
    for (int j = 0; j < Depth; j++) rom_mem[j] = 8'h41;
    base = ts_cnt[0]; dbase = done_cnt[0];
    pulse_start(0, k);
    wait_done(0, dbase, "full");
    check_msg(0, base, "full");
    check("full rom_addr after", 32'(rom_addr_a[0]), 0);

    // Abort during DRAIN of the second byte of "ABCD".
    load_str(8'h41, 8'h42, 8'h43, 8'h44, 8'h00);
    base = ts_cnt[0]; dbase = done_cnt[0];
    pulse_start(0, k);
    wait_ts(0, base + 2, "abort");
    s2 = ts_cyc[0];
    while (cyc < s2 + 3) tick();
    check("abort in drain", 32'({busy_a[0], tx_busy_a[0]}), 32'b11);
    abort_a[0] = 1'b1;
    tick();
    abort_a[0] = 1'b0;
    check("abort idle", 32'(busy_a[0]), 0);
    check("abort rom_addr", 32'(rom_addr_a[0]), 0);
    repeat (40) tick();
    check("abort no more tx", 32'(ts_cnt[0] - base), 2);
    check("abort no done", 32'(done_cnt[0] - dbase), 0);
    check("abort byte_count", 32'(byte_count_a[0]), 1);

    // start and abort together in idle: abort wins, count not cleared.
    start_a[0] = 1'b1; abort_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0; abort_a[0] = 1'b0;
    tick();
    check("start+abort idle", 32'(busy_a[0]), 0);
    check("start+abort count", 32'(byte_count_a[0]), 1);

    // Transmitter busy at start: wait in SEND; a second start mid-message is ignored.
    load_str(8'h50, 8'h51, 8'h52, 8'h00, 8'h00);
    base = ts_cnt[0]; dbase = done_cnt[0];
    hold_a[0] = 1'b1;
    pulse_start(0, k);
    repeat (6) tick();
    check("hold no tx_start", 32'(ts_cnt[0] - base), 0);
    check("hold busy", 32'(busy_a[0]), 1);
    r = cyc;
    hold_a[0] = 1'b0;
    tick();
    check("hold release tx", 32'(ts_cnt[0] - base), 1);
    check("hold tx at fall", 32'(ts_cyc[0] - r), 0);
    check("hold fall seen", 32'(fall_cyc[0] - r), 0);
    pulse_start(0, k);
    wait_done(0, dbase, "restart ignored");
    check_msg(0, base, "restart ignored");

    // Gap instance: busy low first seen in DRAIN, then Gap1 GAP clocks, NEXT, READ, CHECK.
    load_str(8'h58, 8'h59, 8'h5a, 8'h00, 8'h00);
    base = ts_cnt[1]; dbase = done_cnt[1];
    pulse_start(1, k);
    wait_ts(1, base + 1, "gap first");
    s1 = ts_cyc[1];
    wait_ts(1, base + 2, "gap second");
    s2 = ts_cyc[1];
    check("gap byte period", 32'(s2 - s1), 32'(Frame + 5 + Gap1));
    check("gap fall to start", 32'(s2 - fall_cyc[1]), 32'(Gap1 + 4));
    wait_done(1, dbase, "gap");
    check_msg(1, base, "gap");

    // Reset mid-way through the second byte.
    base = ts_cnt[1];
    pulse_start(1, k);
    wait_ts(1, base + 2, "midreset");
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset rom_addr", 32'(rom_addr_a[1]), 0);
    check("midreset tx_data", 32'(tx_data_a[1]), 0);
    check("midreset busy", 32'(busy_a[1]), 0);
    check("midreset byte_count", 32'(byte_count_a[1]), 0);
    check("midreset done", 32'(done_a[1]), 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();

    // Random strings on both instances against the length/content model.
    for (int n = 0; n < 4; n++) begin
      for (int d = 0; d < 2; d++) begin
        int len;
        len = $urandom_range(0, Depth);
        for (int j = 0; j < Depth; j++) rom_mem[j] = 8'($urandom_range(0, 255));
        for (int j = 0; j < len; j++) rom_mem[j] = 8'($urandom_range(1, 255));
        if (len < Depth) rom_mem[len] = 8'h00;
        base = ts_cnt[d]; dbase = done_cnt[d];
        pulse_start(d, k);
        wait_done(d, dbase, "random");
        check_msg(d, base, "random");
        repeat (2) tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
